register_write_arbiter_module: RTL and testbench
================================================

Name: register_write_arbiter_module

Overview:
Sequences write access to one shared 8-bit register from NUM_REQ requesters. Arbitration is round-robin. Each requester uses a 4-phase req/ack handshake.
The register itself has no load enable, so this block drives its data input every cycle: it recirculates reg_q when idle and substitutes the granted requester's data for exactly one cycle per transaction.
It sits between requester logic and the eight_bit_register_structural_module instance. The register's clk/rst come from the same clk/rst as this block.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 8, width of the shared register and of each wdata slice
IDX_W, 1, width of owner index; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request; held high until ack seen
wdata  input  NUM_REQ*DATA_WIDTH  slice i = data of requester i; stable while req[i]=1
ack  output  NUM_REQ  per-requester completion; one-hot or zero
reg_q  input  DATA_WIDTH  current output of the shared register
reg_d  output  DATA_WIDTH  next value driven into the shared register's in port
busy  output  1  high whenever state != IDLE
owner  output  IDX_W  index of granted requester; valid while busy

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, ack=0, busy=0, owner=0, round-robin pointer last=NUM_REQ-1 (requester 0 has top priority first). While rst=1, reg_d=0.
- States:
  - IDLE: if any req bit is set, pick the winner via round-robin, latch owner, go to WRITE. Otherwise stay.
  - WRITE: reg_d = wdata slice [owner]. Lasts exactly 1 cycle. Update last=owner. Go to ACK.
  - ACK: ack[owner]=1. Stay while req[owner]=1. When req[owner]=0, go to IDLE; ack drops the same edge.
- Hold rule: reg_d = reg_q in every non-WRITE, non-reset cycle. The register value never changes except on the WRITE edge or on reset.
- Round-robin: search order is last+1, last+2, …, wrapping modulo NUM_REQ. The first set req bit wins.
  - A requester that just finished is lowest priority in the next IDLE arbitration.
- Latency:
  - req rises, sampled in IDLE at cycle t.
  - busy=1 and reg_d=data at t+1.
  - reg_q=data and ack=1 at t+2.
  - req drop seen in cycle u gives ack=0 and IDLE at u+1.
  - Minimum of one IDLE cycle between transactions, so max rate is 1 write per 4 cycles.
- Arbitration is evaluated only in IDLE. New or dropped req bits of non-owners are ignored while busy.
- Protocol violation: if req[owner] drops during WRITE, the write still completes, ack pulses 1 cycle in ACK, then the block returns to IDLE.
- Reset mid-transaction (any state): the next edge forces all reset values. Any pending write is abandoned and the register clears to 0.
- owner holds its last value in IDLE; it has no meaning there.
- wdata is not captured. Requesters must hold wdata stable from req rise until ack is seen.

Decomposition:
- Shared header/package holds state encodings (IDLE=2'd0, WRITE=2'd1, ACK=2'd2) and the default DATA_WIDTH constant.
- One natural combinational sub-module, round_robin_picker_module: inputs req and last; outputs found and winner index.
- The FSM, pointer, and reg_d mux stay in the top.

Test Plan:
- Reset then idle: rst for 2 cycles, reg_q=8'h00, no req → ack=0, busy=0, reg_d=8'h00 held for 20 cycles.
- Single write: req[0]=1, wdata[7:0]=8'hA5 at cycle t → reg_d=8'hA5 at t+1 only, reg_q=8'hA5 and ack[0]=1 at t+2; drop req at t+4 → ack=0, busy=0 at t+5; reg_q stays 8'hA5.
- Contention/fairness: req=2'b11 from reset, data0=8'h11, data1=8'h22, each requester re-requests immediately after its ack falls → writes alternate 8'h11, 8'h22, 8'h11, 8'h22; the first grant goes to requester 0.
- Long hold: requester 1 keeps req high 10 cycles after ack while req[0] rises → ack[1] stays 1 for those cycles, reg_q unchanged, requester 0 is granted only after IDLE.
- Reset mid-op: assert rst during WRITE carrying 8'h3C over a prior 8'h55 → reg_q=8'h00 after the edge, ack=0, state IDLE; pointer restarts so requester 0 wins the next 2'b11 request.
- Protocol violation: req[1] drops during WRITE carrying 8'h7E → reg_q=8'h7E, ack[1]=1 for exactly one cycle, then IDLE.

Source files
------------

// File: rtl/register_write_arbiter_module_pkg.sv
// Shared definitions for the register write arbiter: FSM state encoding and
// the default width of the shared register.
package register_write_arbiter_module_pkg;

  // IDLE waits for requests, WRITE drives the winner's data for one cycle,
  // ACK holds the completion handshake until the owner releases its request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/register_write_arbiter_module_round_robin_picker.sv
// Combinational round-robin search: starting just after the last served
// requester, report the first requester with its request bit set.
module round_robin_picker_module #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand;

  // Walk last+1, last+2, ... modulo NUM_REQ so the previous owner is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter_module.sv
// Arbitrates write access to a single shared register among NUM_REQ
// requesters using a 4-phase req/ack handshake. The register has no load
// enable, so reg_d recirculates reg_q except during the single WRITE cycle.
module register_write_arbiter_module
  import register_write_arbiter_module_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  input  logic [DATA_WIDTH-1:0]         reg_q,
  output logic [DATA_WIDTH-1:0]         reg_d,
  output logic                          busy,
  output logic [IDX_W-1:0]              owner
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q,  last_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_winner;

  round_robin_picker_module #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  // State, owner and round-robin pointer; the pointer restarts so requester 0 is favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state, handshake and register data mux; reg_d only departs from reg_q in WRITE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    reg_d   = reg_q;
    ack     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_winner;
          state_d = WRITE;
        end
      end
      WRITE: begin
        reg_d   = wdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        last_d  = owner_q;
        state_d = ACK;
      end
      ACK: begin
        ack[owner_q] = 1'b1;
        if (!req[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      reg_d = '0;
    end
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_register_write_arbiter_module.sv
// Self-checking bench for register_write_arbiter_module: directed scenarios
// followed by randomized transactions against a transaction-level model.
module tb_register_write_arbiter_module;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int IW = 1;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    regQ;
  logic [DW-1:0]    regD;
  logic             busy;
  logic [IW-1:0]    owner;

  int checks = 0;
  int errors = 0;
  int modelLast;
  logic [DW-1:0] expReg;

  register_write_arbiter_module #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .IDX_W      (IW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .ack   (ack),
    .reg_q (regQ),
    .reg_d (regD),
    .busy  (busy),
    .owner (owner)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared 8-bit register: loads reg_d every edge, clears on reset.
  always @(posedge clk) begin
    regQ <= rst ? '0 : regD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Round-robin reference: build the service order starting after the last owner.
  function automatic int pickWinner(input logic [NR-1:0] r, input int last);
    int order[$];
    for (int k = 0; k < NR; k++) order.push_back((last + 1 + k) % NR);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic setData(input int idx, input logic [DW-1:0] v);
    wdata[idx*DW +: DW] = v;
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    req = '0;
    repeat (cycles) begin
      tick();
      checkOutput("rst_reg_d", 32'(regD), 32'h0);
      checkOutput("rst_ack", 32'(ack), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_reg_q", 32'(regQ), 32'h0);
    end
    rst = 1'b0;
    modelLast = NR - 1;
    expReg = '0;
  endtask

  // One full handshake: request in IDLE, grant, write, ack, optional hold, release.
  task automatic applyStimulus(input logic [NR-1:0] reqVec, input int holdCycles, input logic [NR-1:0] sideReq);
    int w;
    logic [DW-1:0] d;
    req = reqVec;
    w = pickWinner(reqVec, modelLast);
    d = wdata[w*DW +: DW];
    #1;
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_hold", 32'(regD), 32'(expReg));
    tick();
    checkOutput("write_busy", 32'(busy), 32'h1);
    checkOutput("write_owner", 32'(owner), 32'(w));
    checkOutput("write_reg_d", 32'(regD), 32'(d));
    checkOutput("write_ack", 32'(ack), 32'h0);
    tick();
    expReg = d;
    modelLast = w;
    checkOutput("ack_onehot", 32'(ack), 32'(1 << w));
    checkOutput("ack_reg_q", 32'(regQ), 32'(expReg));
    checkOutput("ack_hold", 32'(regD), 32'(expReg));
    req = req | sideReq;
    repeat (holdCycles) begin
      tick();
      checkOutput("hold_ack", 32'(ack), 32'(1 << w));
      checkOutput("hold_owner", 32'(owner), 32'(w));
      checkOutput("hold_reg_q", 32'(regQ), 32'(expReg));
      checkOutput("hold_reg_d", 32'(regD), 32'(expReg));
    end
    req[w] = 1'b0;
    #1;
    checkOutput("drop_ack_still", 32'(ack), 32'(1 << w));
    tick();
    checkOutput("release_ack", 32'(ack), 32'h0);
    checkOutput("release_busy", 32'(busy), 32'h0);
    checkOutput("release_reg_q", 32'(regQ), 32'(expReg));
  endtask

  initial begin
    logic [DW-1:0] fairSeq [4];
    rst = 1'b1;
    req = '0;
    wdata = '0;
    modelLast = NR - 1;
    expReg = '0;

    // Reset then idle for 20 cycles.
    doReset(2);
    repeat (20) begin
      tick();
      checkOutput("idle_ack", 32'(ack), 32'h0);
      checkOutput("idle_busy20", 32'(busy), 32'h0);
      checkOutput("idle_reg_d", 32'(regD), 32'h0);
    end

    // Single write of A5 by requester 0, released two cycles after ack.
    setData(0, 8'hA5);
    applyStimulus(2'b01, 2, 2'b00);
    tick();
    checkOutput("single_reg_q", 32'(regQ), 32'hA5);

    // Contention from reset: writes must alternate 11, 22, 11, 22.
    doReset(2);
    setData(0, 8'h11);
    setData(1, 8'h22);
    fairSeq[0] = 8'h11; fairSeq[1] = 8'h22; fairSeq[2] = 8'h11; fairSeq[3] = 8'h22;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 1, 2'b00);
      checkOutput("fair_seq", 32'(regQ), 32'(fairSeq[k]));
    end
    req = '0;
    tick();

    // Long hold by requester 1 while requester 0 raises its request.
    setData(1, 8'h99);
    setData(0, 8'h44);
    applyStimulus(2'b10, 10, 2'b01);
    applyStimulus(2'b01, 0, 2'b00);
    checkOutput("longhold_next", 32'(regQ), 32'h44);

    // Reset during WRITE: the 3C write is abandoned and the register clears.
    setData(0, 8'h55);
    applyStimulus(2'b01, 0, 2'b00);
    setData(0, 8'h3C);
    req = 2'b01;
    #1;
    tick();
    checkOutput("midrst_write", 32'(regD), 32'h3C);
    rst = 1'b1;
    req = '0;
    #1;
    checkOutput("midrst_reg_d", 32'(regD), 32'h0);
    tick();
    checkOutput("midrst_reg_q", 32'(regQ), 32'h0);
    checkOutput("midrst_ack", 32'(ack), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    modelLast = NR - 1;
    expReg = '0;
    setData(0, 8'hAA);
    setData(1, 8'hBB);
    applyStimulus(2'b11, 0, 2'b00);
    checkOutput("midrst_winner0", 32'(regQ), 32'hAA);
    req = '0;
    tick();

    // Protocol violation: requester 1 drops its request during WRITE.
    setData(1, 8'h7E);
    req = 2'b10;
    #1;
    tick();
    checkOutput("viol_write", 32'(regD), 32'h7E);
    req = '0;
    #1;
    tick();
    checkOutput("viol_ack", 32'(ack), 32'h2);
    checkOutput("viol_reg_q", 32'(regQ), 32'h7E);
    tick();
    checkOutput("viol_ack_drop", 32'(ack), 32'h0);
    checkOutput("viol_idle", 32'(busy), 32'h0);
    checkOutput("viol_keep", 32'(regQ), 32'h7E);
    modelLast = 1;
    expReg = 8'h7E;

    // Randomized transactions with side requests arriving during ACK.
    for (int n = 0; n < 40; n++) begin
      logic [NR-1:0] rv;
      for (int i = 0; i < NR; i++) begin
        if (!req[i]) setData(i, DW'($urandom));
      end
      rv = NR'($urandom_range(1, (1 << NR) - 1)) | req;
      applyStimulus(rv, $urandom_range(0, 3), NR'($urandom_range(0, (1 << NR) - 1)));
    end
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
